mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter WIDTH, default 32, address and data width.
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 ifu_req_valid / ifu_req_ready  input / output  1 / 1  IFU read-request handshake.
REQ-005 ifu_addr  input  WIDTH  IFU fetch address.
REQ-006 ifu_resp_valid / ifu_resp_ready  output / input  1 / 1  IFU response handshake.
REQ-007 ifu_rdata  output  WIDTH  fetched word.
REQ-008 lsu_req_valid / lsu_req_ready  input / output  1 / 1  LSU request handshake.
REQ-009 lsu_addr, lsu_wdata  input  WIDTH  LSU address and store data.
REQ-010 lsu_wen  input  1  store when 1, load when 0.
REQ-011 lsu_wmask  input  WIDTH/8  byte-enable mask for stores.
REQ-012 lsu_resp_valid / lsu_resp_ready  output / input  1 / 1  LSU response handshake.
REQ-013 lsu_rdata  output  WIDTH  load data; don't-care for stores.
REQ-014 mem_req_valid / mem_req_ready  output / input  1 / 1  downstream memory request handshake.
REQ-015 mem_addr, mem_wdata  output  WIDTH; mem_wen  output  1; mem_wmask  output  WIDTH/8.
REQ-016 mem_resp_valid / mem_resp_ready  input / output  1 / 1; mem_rdata  input  WIDTH.

Function
REQ-017 FSM states: IDLE, REQ, WAIT_RESP, RESP.
REQ-018 IDLE: if any master req_valid, grant one master, latch its request fields, go to REQ.
REQ-019 Grant: a master's req_ready is 1 only in IDLE for the granted master; the request transfers on the cycle of that grant.
REQ-020 REQ: mem_req_valid=1 with latched fields; on mem_req_ready go to WAIT_RESP.
REQ-021 WAIT_RESP: mem_resp_ready=1; on mem_resp_valid latch mem_rdata, go to RESP.
REQ-022 RESP: assert granted master's resp_valid with latched data; hold stable until that master's resp_ready, then go to IDLE.
REQ-023 Exactly one transaction outstanding; the non-granted master's req_ready and resp_valid stay 0.
REQ-024 IFU requests always drive mem_wen=0, mem_wmask=0.
REQ-025 Minimum latency with zero-wait memory: request accepted cycle N, resp_valid cycle N+3.
REQ-026 Request fields latched at grant; later changes to master inputs have no effect.
REQ-027 mem_* outputs and all resp_valid are 0 outside their states.

Reset
REQ-028 rst asserted, in any state including mid-transaction: FSM to IDLE, all valid/ready outputs 0, latched data 0, priority pointer points to LSU.
REQ-029 An in-flight memory response after reset is dropped; no master sees it.

Configuration
REQ-030 Macro MEM_ARB_ROUND_ROBIN_EN defined: on simultaneous requests in IDLE, grant the master not granted last; pointer updates on each grant.
REQ-031 Macro undefined: fixed priority, LSU always wins simultaneous requests; no pointer register exists.

Structure
REQ-032 Shared package holds the state enum (IDLE, REQ, WAIT_RESP, RESP) and the master-ID encoding (MST_IFU, MST_LSU).
REQ-033 No sub-module; a single flat module with one FSM and request/response holding registers.

Verification
REQ-034 IFU only, addr 0x80000000, memory returns 0x00000413 with zero wait -> ifu_resp_valid at request cycle +3, ifu_rdata=0x00000413.
REQ-035 LSU store addr 0x80001000, wdata 0xDEADBEEF, wmask 0xF -> mem_wen=1, mem fields match; lsu_resp_valid once, ifu never responds.
REQ-036 Both request in the same IDLE cycle, macro undefined -> LSU granted first, IFU next; macro defined with last grant LSU -> IFU granted first.
REQ-037 mem_req_ready low 4 cycles and lsu_resp_ready low 3 cycles -> mem fields and lsu_rdata stable throughout, exactly one handshake each.
REQ-038 rst asserted during WAIT_RESP, then mem_resp_valid with 0x12345678 -> no master resp_valid, FSM IDLE, next IFU request served normally.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared types for the two-master memory arbiter: FSM state encoding and master IDs.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_REQ       = 2'd1,
        S_WAIT_RESP = 2'd2,
        S_RESP      = 2'd3
    } state_t;

    typedef enum logic {
        MST_IFU = 1'b0,
        MST_LSU = 1'b1
    } mst_t;

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates IFU and LSU requests onto one memory port, one transaction at a time.
// Define MEM_ARB_ROUND_ROBIN_EN for alternating priority; otherwise the LSU always wins ties.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,

    input  logic               ifu_req_valid,
    output logic               ifu_req_ready,
    input  logic [WIDTH-1:0]   ifu_addr,
    output logic               ifu_resp_valid,
    input  logic               ifu_resp_ready,
    output logic [WIDTH-1:0]   ifu_rdata,

    input  logic               lsu_req_valid,
    output logic               lsu_req_ready,
    input  logic [WIDTH-1:0]   lsu_addr,
    input  logic [WIDTH-1:0]   lsu_wdata,
    input  logic               lsu_wen,
    input  logic [WIDTH/8-1:0] lsu_wmask,
    output logic               lsu_resp_valid,
    input  logic               lsu_resp_ready,
    output logic [WIDTH-1:0]   lsu_rdata,

    output logic               mem_req_valid,
    input  logic               mem_req_ready,
    output logic [WIDTH-1:0]   mem_addr,
    output logic [WIDTH-1:0]   mem_wdata,
    output logic               mem_wen,
    output logic [WIDTH/8-1:0] mem_wmask,
    input  logic               mem_resp_valid,
    output logic               mem_resp_ready,
    input  logic [WIDTH-1:0]   mem_rdata
);

    state_t             r_state;
    mst_t               r_mst;
    logic [WIDTH-1:0]   r_addr;
    logic [WIDTH-1:0]   r_wdata;
    logic               r_wen;
    logic [WIDTH/8-1:0] r_wmask;
    logic [WIDTH-1:0]   r_rdata;

    logic w_idle;
    logic w_prio_lsu;
    logic w_gnt_lsu;
    logic w_gnt_any;
    logic w_resp_ready;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    // Set when the LSU should win the next tie, i.e. the IFU was granted last.
    logic r_prio_lsu;
    assign w_prio_lsu = r_prio_lsu;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_prio_lsu <= 1'b1;
        else if (w_gnt_any)
            r_prio_lsu <= ~w_gnt_lsu;
    end
`else
    assign w_prio_lsu = 1'b1;
`endif

    // Grants are offered only while reset is released so no ready leaks out during reset.
    assign w_idle       = (r_state == S_IDLE) && !rst;
    assign w_gnt_lsu    = lsu_req_valid && (!ifu_req_valid || w_prio_lsu);
    assign w_gnt_any    = w_idle && (ifu_req_valid || lsu_req_valid);
    assign w_resp_ready = (r_mst == MST_LSU) ? lsu_resp_ready : ifu_resp_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_mst   <= MST_LSU;
            r_addr  <= '0;
            r_wdata <= '0;
            r_wen   <= 1'b0;
            r_wmask <= '0;
            r_rdata <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_gnt_any) begin
                        r_state <= S_REQ;
                        if (w_gnt_lsu) begin
                            r_mst   <= MST_LSU;
                            r_addr  <= lsu_addr;
                            r_wdata <= lsu_wdata;
                            r_wen   <= lsu_wen;
                            r_wmask <= lsu_wmask;
                        end else begin
                            r_mst   <= MST_IFU;
                            r_addr  <= ifu_addr;
                            r_wdata <= '0;
                            r_wen   <= 1'b0;
                            r_wmask <= '0;
                        end
                    end
                end
                S_REQ: begin
                    if (mem_req_ready)
                        r_state <= S_WAIT_RESP;
                end
                S_WAIT_RESP: begin
                    if (mem_resp_valid) begin
                        r_rdata <= mem_rdata;
                        r_state <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (w_resp_ready)
                        r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign ifu_req_ready  = w_idle && ifu_req_valid && !w_gnt_lsu;
    assign lsu_req_ready  = w_idle && w_gnt_lsu;

    assign ifu_resp_valid = (r_state == S_RESP) && (r_mst == MST_IFU);
    assign lsu_resp_valid = (r_state == S_RESP) && (r_mst == MST_LSU);
    assign ifu_rdata      = r_rdata;
    assign lsu_rdata      = r_rdata;

    // Request fields are only presented while the request is live.
    assign mem_req_valid  = (r_state == S_REQ);
    assign mem_addr       = mem_req_valid ? r_addr  : '0;
    assign mem_wdata      = mem_req_valid ? r_wdata : '0;
    assign mem_wen        = mem_req_valid && r_wen;
    assign mem_wmask      = mem_req_valid ? r_wmask : '0;
    assign mem_resp_ready = (r_state == S_WAIT_RESP);

endmodule
